// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and the datapath it steers:
// hazard/branch/halt requests in, register enables, flushes and status out.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             hazard;
  logic             branch_taken;
  logic             halt_id;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       state;
  logic             halted;
  logic             stall_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output start, hazard, branch_taken, halt_id,
    input  pc_we, ifid_we, ifid_flush, idex_flush,
    input  state, halted, stall_err, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, hazard, branch_taken, halt_id,
    output pc_we, ifid_we, ifid_flush, idex_flush,
    output state, halted, stall_err, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/drain/halt sequencer for the 5-stage pipeline: Mealy enables and flushes
// for PC, IF/ID and ID/EX, plus saturating performance counters and stall_err.
module pipeline_sequencer #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_STALL    = 2
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_sequencer_if.slave ctl
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [SW-1:0] RUN_MAX    = SW'(MAX_STALL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_DRAIN  = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [SW-1:0] run_q, run_d;
  logic          err_q, err_d;

  logic          pc_we_d, ifid_we_d, ifid_flush_d, idex_flush_d, halted_d;
  logic [2:0]    cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    run_d        = '0;
    pc_we_d      = 1'b0;
    ifid_we_d    = 1'b0;
    ifid_flush_d = 1'b1;
    idex_flush_d = 1'b1;
    halted_d     = 1'b0;
    cnt_inc      = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        if (ctl.start) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_inc[0] = 1'b1;
        if (ctl.branch_taken) begin
          // Hazard/HLT in the same cycle belong to squashed instructions.
          pc_we_d    = 1'b1;
          ifid_we_d  = 1'b1;
          cnt_inc[2] = 1'b1;
        end else if (ctl.hazard) begin
          ifid_flush_d = 1'b0;
          cnt_inc[1]   = 1'b1;
          run_d        = (run_q == RUN_MAX) ? run_q : run_q + SW'(1);
        end else if (ctl.halt_id) begin
          ifid_we_d    = 1'b1;
          idex_flush_d = 1'b0;
          drain_d      = DRAIN_LOAD;
          state_d      = S_DRAIN;
        end else begin
          pc_we_d      = 1'b1;
          ifid_we_d    = 1'b1;
          ifid_flush_d = 1'b0;
          idex_flush_d = 1'b0;
        end
      end
      S_DRAIN: begin
        cnt_inc[0] = 1'b1;
        ifid_we_d  = 1'b1;
        if (drain_q == '0) state_d = S_HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      S_HALTED: begin
        halted_d = 1'b1;
        if (ctl.start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_q | (run_d == RUN_MAX);

    // Reset overrides the Mealy outputs in the same cycle, not one later.
    if (rst) begin
      pc_we_d      = 1'b0;
      ifid_we_d    = 1'b0;
      ifid_flush_d = 1'b1;
      idex_flush_d = 1'b1;
      halted_d     = 1'b0;
    end
  end

  // Counters: 0 = cycles in RUN/DRAIN, 1 = hazard stalls, 2 = branch flushes.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign cnt_val[gi] = cnt_q;
  end

  assign ctl.pc_we      = pc_we_d;
  assign ctl.ifid_we    = ifid_we_d;
  assign ctl.ifid_flush = ifid_flush_d;
  assign ctl.idex_flush = idex_flush_d;
  assign ctl.halted     = halted_d;
  assign ctl.state      = state_q;
  assign ctl.stall_err  = err_q;
  assign ctl.cycle_cnt  = cnt_val[0];
  assign ctl.stall_cnt  = cnt_val[1];
  assign ctl.flush_cnt  = cnt_val[2];

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs from a
// behavioural model; a negedge monitor pops and compares both DUT instances.
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 3;
  localparam int MAX_STALL    = 2;
  localparam longint SMALL_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(32)) ifb ();
  pipeline_sequencer_if #(.CNT_W(4))  ifs ();

  pipeline_sequencer #(.CNT_W(32), .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_STALL(MAX_STALL))
    dut (.clk(clk), .rst(rst), .ctl(ifb.slave));
  pipeline_sequencer #(.CNT_W(4), .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_STALL(MAX_STALL))
    dut_s (.clk(clk), .rst(rst), .ctl(ifs.slave));

  assign ifs.start        = ifb.start;
  assign ifs.hazard       = ifb.hazard;
  assign ifs.branch_taken = ifb.branch_taken;
  assign ifs.halt_id      = ifb.halt_id;

  typedef struct {
    logic [3:0] ctrl;    // {pc_we, ifid_we, ifid_flush, idex_flush}
    logic       halted;
    logic [1:0] st;
    logic       err;
    longint     cyc;
    longint     stl;
    longint     fls;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 drain, 3 halted.
  int     m_mode = 0;
  int     m_left = 0;
  int     m_streak = 0;
  bit     m_err = 0;
  longint m_cyc = 0, m_stl = 0, m_fls = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic longint sat(input longint v);
    return (v > SMALL_MAX) ? SMALL_MAX : v;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_left = 0; m_streak = 0; m_err = 0;
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else begin
      case (m_mode)
        0, 3: if (ifb.start) m_mode = 1;
        1: begin
          m_cyc++;
          if (ifb.branch_taken) begin
            m_fls++; m_streak = 0;
          end else if (ifb.hazard) begin
            m_stl++; m_streak++;
            if (m_streak >= MAX_STALL) m_err = 1;
          end else if (ifb.halt_id) begin
            m_mode = 2; m_left = DRAIN_CYCLES; m_streak = 0;
          end else begin
            m_streak = 0;
          end
        end
        default: begin
          m_cyc++;
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
      endcase
    end
  endtask

  function automatic exp_t expect_now();
    exp_t x;
    x.st = 2'(m_mode); x.err = m_err;
    x.cyc = m_cyc; x.stl = m_stl; x.fls = m_fls;
    x.halted = (!rst && m_mode == 3);
    if (rst || m_mode == 0 || m_mode == 3) x.ctrl = 4'b0011;
    else if (m_mode == 2)                  x.ctrl = 4'b0111;
    else if (ifb.branch_taken)             x.ctrl = 4'b1111;
    else if (ifb.hazard)                   x.ctrl = 4'b0001;
    else if (ifb.halt_id)                  x.ctrl = 4'b0110;
    else                                   x.ctrl = 4'b1100;
    return x;
  endfunction

  task automatic cycle(input logic [4:0] v);
    @(posedge clk);
    model_step();
    #1;
    {rst, ifb.start, ifb.hazard, ifb.branch_taken, ifb.halt_id} = v;
    sbq.push_back(expect_now());
  endtask

  // {rst, start, hazard, branch_taken, halt_id}
  logic [4:0] dir [0:26] = '{
    5'b10000, 5'b10000, 5'b10000, 5'b00111, 5'b01000,
    5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000,
    5'b00100, 5'b00100, 5'b00000, 5'b00111, 5'b00000,
    5'b00001, 5'b00110, 5'b10000, 5'b00000, 5'b01000,
    5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000,
    5'b00000, 5'b01000
  };

  initial begin
    logic [4:0] v;
    bit hz_prev;
    {rst, ifb.start, ifb.hazard, ifb.branch_taken, ifb.halt_id} = 5'b10000;
    for (int i = 0; i < 27; i++) cycle(dir[i]);
    for (int i = 0; i < 20; i++) cycle(5'b00000);
    hz_prev = 0;
    for (int i = 0; i < 1500; i++) begin
      v[4] = ($urandom_range(0, 99) == 0);
      v[3] = ($urandom_range(0, 3) == 0);
      v[2] = hz_prev ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      v[1] = ($urandom_range(0, 5) == 0);
      v[0] = ($urandom_range(0, 9) == 0);
      hz_prev = v[2];
      cycle(v);
    end
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain_queue: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ctrl", {ifb.pc_we, ifb.ifid_we, ifb.ifid_flush, ifb.idex_flush}, e.ctrl);
      chk("halted", ifb.halted, e.halted);
      chk("state", ifb.state, e.st);
      chk("stall_err", ifb.stall_err, e.err);
      chk("cycle_cnt", ifb.cycle_cnt, e.cyc);
      chk("stall_cnt", ifb.stall_cnt, e.stl);
      chk("flush_cnt", ifb.flush_cnt, e.fls);
      chk("cycle_cnt_w4", ifs.cycle_cnt, sat(e.cyc));
      chk("stall_cnt_w4", ifs.stall_cnt, sat(e.stl));
      chk("flush_cnt_w4", ifs.flush_cnt, sat(e.fls));
    end
  end

endmodule
